// File: rtl/vreg_dump_unit.sv
// vreg_dump_unit
// Debug readout engine for the vector register file. On start it walks the
// inclusive register range first_reg..last_reg through one read port. It
// snapshots each 256-bit register in a single LOAD cycle, then streams the
// snapshot out as 32-bit beats, least significant word first, over a
// valid/ready handshake.
// All outputs come straight from flops.

module vreg_dump_unit #(
  parameter int VLEN   = 256,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [VLEN-1:0]   rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_reg,
  output logic [2:0]        out_beat,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [2:0] LAST_BEAT = 3'(VLEN / OUT_W - 1);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] cur_reg_q,   cur_reg_d;
  logic [ADDR_W-1:0] last_reg_q,  last_reg_d;
  logic              err_q,       err_d;
  logic [VLEN-1:0]   buf_q,       buf_d;
  logic [2:0]        beat_q,      beat_d;

  // Registered versions of the status/handshake outputs, decoded from the
  // next state so they line up with the state they describe.
  logic              out_valid_q, out_valid_d;
  logic              out_last_q,  out_last_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              range_err_q, range_err_d;
  logic [ADDR_W-1:0] rf_addr_q,   rf_addr_d;

  // Next-state logic for the walk: latch range, snapshot, shift out beats.
  always_comb begin
    state_d    = state_q;
    cur_reg_d  = cur_reg_q;
    last_reg_d = last_reg_q;
    err_d      = err_q;
    buf_d      = buf_q;
    beat_d     = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_reg_d  = first_reg;
          last_reg_d = last_reg;
          if (first_reg <= last_reg) begin
            state_d = ST_LOAD;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // R0 is hard-wired zero regardless of what the read port returns.
        if (cur_reg_q == {ADDR_W{1'b0}}) begin
          buf_d = {VLEN{1'b0}};
        end else begin
          buf_d = rf_data;
        end
        beat_d  = 3'd0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (out_ready) begin
          buf_d  = {{OUT_W{1'b0}}, buf_q[VLEN-1:OUT_W]};
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST_BEAT) begin
            if (cur_reg_q == last_reg_q) begin
              state_d = ST_DONE;
            end else begin
              cur_reg_d = cur_reg_q + ADDR_W'(1);
              state_d   = ST_LOAD;
            end
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = 1'b0;
      end
    endcase
  end

  // Output decode from the upcoming state, so every output is a flop.
  always_comb begin
    out_valid_d = (state_d == ST_SEND);
    busy_d      = (state_d == ST_LOAD) || (state_d == ST_SEND);
    done_d      = (state_d == ST_DONE);
    range_err_d = (state_d == ST_DONE) && err_d;
    out_last_d  = (state_d == ST_SEND) && (beat_d == LAST_BEAT) &&
                  (cur_reg_d == last_reg_d);
    if (state_d == ST_LOAD) begin
      rf_addr_d = cur_reg_d;
    end else begin
      rf_addr_d = {ADDR_W{1'b0}};
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cur_reg_q   <= {ADDR_W{1'b0}};
      last_reg_q  <= {ADDR_W{1'b0}};
      err_q       <= 1'b0;
      buf_q       <= {VLEN{1'b0}};
      beat_q      <= 3'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      rf_addr_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cur_reg_q   <= cur_reg_d;
      last_reg_q  <= last_reg_d;
      err_q       <= err_d;
      buf_q       <= buf_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      range_err_q <= range_err_d;
      rf_addr_q   <= rf_addr_d;
    end
  end

  assign rf_addr   = rf_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = buf_q[OUT_W-1:0];
  assign out_reg   = cur_reg_q;
  assign out_beat  = beat_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign range_err = range_err_q;

endmodule
